// File: rtl/obstacle_pkg.sv
// Shared types, screen geometry, colours and the box-overlap helper for the object datapath.
// The enum carries the obstacle repaint states only when OBSTACLE_BOUNCE_EN is defined.
package obstacle_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;
    localparam int unsigned SPRITE   = 4;

    localparam logic [2:0] C_PLAYER = 3'b010;
    localparam logic [2:0] C_OBS    = 3'b100;
    localparam logic [2:0] C_BG     = 3'b000;

    typedef enum logic [2:0] {
        S_INIT,
        S_DRAW,
        S_WAIT,
        S_ERASE,
`ifdef OBSTACLE_BOUNCE_EN
        S_OBS_ERASE,
        S_OBS_DRAW,
`endif
        S_UPDATE,
        S_DONE
    } state_e;

    // Inclusive overlap of two axis-aligned boxes; 9-bit operands so edge sums never wrap.
    function automatic logic overlap(input logic [8:0] ax, input logic [8:0] ay,
                                     input logic [8:0] aw, input logic [8:0] ah,
                                     input logic [8:0] bx, input logic [8:0] by,
                                     input logic [8:0] bw, input logic [8:0] bh);
        return (ax <= bx + bw - 9'd1) && (ax + aw - 9'd1 >= bx) &&
               (ay <= by + bh - 9'd1) && (ay + ah - 9'd1 >= by);
    endfunction

endpackage

// File: rtl/object_datapath_rate_divider.sv
// Step-rate divider: counts enabled cycles and pulses tick for one cycle at each wrap.
// The count clears whenever enable drops, so a paused run restarts a full period.
module rate_divider #(
    parameter int unsigned TICKS_PER_STEP = 833333
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int unsigned   CW   = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS_PER_STEP - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    always_comb begin
        cnt_d  = '0;
        tick_d = 1'b0;
        if (enable) begin
            if (cnt_q == LAST) begin
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/object_datapath.sv
// Moves a 4x4 player sprite one pixel right per step and paints it through the VGA pixel port.
// Define OBSTACLE_BOUNCE_EN to make the obstacle bounce vertically and be repainted every step.
module object_datapath
    import obstacle_pkg::*;
#(
    parameter int unsigned X_START        = 8,
    parameter int unsigned Y_START        = 56,
    parameter int unsigned X_END          = 152,
    parameter int unsigned OBS_X          = 80,
    parameter int unsigned OBS_Y          = 52,
    parameter int unsigned OBS_W          = 8,
    parameter int unsigned OBS_H          = 16,
    parameter int unsigned TICKS_PER_STEP = 833333
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       draw,
    input  logic       write_en,
    input  logic       move_up,
    input  logic       move_down,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour_out,
    output logic       plot,
    output logic       finish
);

    localparam logic [6:0] Y_MAX        = 7'(SCREEN_H - SPRITE);
    localparam logic [3:0] OBS_COL_LAST = 4'(OBS_W - 1);
    localparam logic [3:0] OBS_ROW_LAST = 4'(OBS_H - 1);

    state_e     state_q, state_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [3:0] spr_k_q, spr_k_d;
    logic [3:0] obs_col_q, obs_col_d;
    logic [3:0] obs_row_q, obs_row_d;
    logic       pend_q, pend_d;
    logic       finish_q, finish_d;
    logic [7:0] x_out_q, x_out_d;
    logic [6:0] y_out_q, y_out_d;
    logic [2:0] colour_q, colour_d;
    logic       plot_q, plot_d;

    logic       tick;
    logic [6:0] obs_y;
    logic [3:0] obs_col_nxt, obs_row_nxt;
    logic       obs_last, spr_last;
    logic [7:0] x_new;
    logic [6:0] y_new;
    logic       hit;
    logic [7:0] obs_px_x, spr_px_x;
    logic [6:0] obs_px_y, spr_px_y;

`ifdef OBSTACLE_BOUNCE_EN
    localparam logic [6:0] OBS_Y_MAX = 7'(SCREEN_H - OBS_H);
    logic [6:0] obs_y_q, obs_y_d;
    logic       obs_dn_q, obs_dn_d;
    assign obs_y = obs_y_q;
`else
    assign obs_y = 7'(OBS_Y);
`endif

    rate_divider #(.TICKS_PER_STEP(TICKS_PER_STEP)) u_rate_divider (
        .clock  (clock),
        .reset  (reset),
        .enable (draw),
        .tick   (tick)
    );

    // Pixel addresses for the current paint counter values.
    assign obs_px_x = 8'(OBS_X) + 8'(obs_col_q);
    assign obs_px_y = obs_y + 7'(obs_row_q);
    assign spr_px_x = x_q + 8'(spr_k_q[1:0]);
    assign spr_px_y = y_q + 7'(spr_k_q[3:2]);
    assign spr_last = (spr_k_q == 4'hF);
    assign obs_last = (obs_col_q == OBS_COL_LAST) && (obs_row_q == OBS_ROW_LAST);

    // Row-major obstacle scan: column fastest, both wrap to zero after the last pixel.
    always_comb begin
        obs_col_nxt = obs_col_q + 4'd1;
        obs_row_nxt = obs_row_q;
        if (obs_col_q == OBS_COL_LAST) begin
            obs_col_nxt = '0;
            obs_row_nxt = (obs_row_q == OBS_ROW_LAST) ? 4'd0 : obs_row_q + 4'd1;
        end
    end

    // Candidate position for the next step; opposing moves cancel.
    always_comb begin
        y_new = y_q;
        if (move_up && !move_down && (y_q != 7'd0)) begin
            y_new = y_q - 7'd1;
        end else if (move_down && !move_up && (y_q < Y_MAX)) begin
            y_new = y_q + 7'd1;
        end
    end

    assign x_new = x_q + 8'd1;
    assign hit   = overlap(9'(x_new), 9'(y_new), 9'(SPRITE), 9'(SPRITE),
                           9'(OBS_X), 9'(obs_y), 9'(OBS_W), 9'(OBS_H))
                   || (9'(x_new) >= 9'(X_END));

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        spr_k_d   = spr_k_q;
        obs_col_d = obs_col_q;
        obs_row_d = obs_row_q;
        pend_d    = pend_q | tick;
        finish_d  = finish_q;
        x_out_d   = x_out_q;
        y_out_d   = y_out_q;
        colour_d  = colour_q;
        plot_d    = 1'b0;
`ifdef OBSTACLE_BOUNCE_EN
        obs_y_d   = obs_y_q;
        obs_dn_d  = obs_dn_q;
`endif
        case (state_q)
            S_INIT: begin
                x_out_d   = obs_px_x;
                y_out_d   = obs_px_y;
                colour_d  = C_OBS;
                plot_d    = write_en;
                obs_col_d = obs_col_nxt;
                obs_row_d = obs_row_nxt;
                if (obs_last) state_d = S_DRAW;
            end
            S_DRAW: begin
                x_out_d  = spr_px_x;
                y_out_d  = spr_px_y;
                colour_d = C_PLAYER;
                plot_d   = write_en;
                spr_k_d  = spr_k_q + 4'd1;
                if (spr_last) state_d = S_WAIT;
            end
            S_WAIT: begin
                // A tick seen earlier is held in pend_q so one step happens per tick.
                if (draw && (tick || pend_q)) begin
                    pend_d  = 1'b0;
                    state_d = S_ERASE;
                end
            end
            S_ERASE: begin
                x_out_d  = spr_px_x;
                y_out_d  = spr_px_y;
                colour_d = C_BG;
                plot_d   = write_en;
                spr_k_d  = spr_k_q + 4'd1;
`ifdef OBSTACLE_BOUNCE_EN
                if (spr_last) state_d = S_OBS_ERASE;
`else
                if (spr_last) state_d = S_UPDATE;
`endif
            end
`ifdef OBSTACLE_BOUNCE_EN
            S_OBS_ERASE: begin
                x_out_d   = obs_px_x;
                y_out_d   = obs_px_y;
                colour_d  = C_BG;
                plot_d    = write_en;
                obs_col_d = obs_col_nxt;
                obs_row_d = obs_row_nxt;
                if (obs_last) begin
                    state_d = S_OBS_DRAW;
                    if (obs_dn_q) begin
                        if (obs_y_q < OBS_Y_MAX) begin
                            obs_y_d = obs_y_q + 7'd1;
                        end else begin
                            obs_y_d  = obs_y_q - 7'd1;
                            obs_dn_d = 1'b0;
                        end
                    end else begin
                        if (obs_y_q != 7'd0) begin
                            obs_y_d = obs_y_q - 7'd1;
                        end else begin
                            obs_y_d  = obs_y_q + 7'd1;
                            obs_dn_d = 1'b1;
                        end
                    end
                end
            end
            S_OBS_DRAW: begin
                x_out_d   = obs_px_x;
                y_out_d   = obs_px_y;
                colour_d  = C_OBS;
                plot_d    = write_en;
                obs_col_d = obs_col_nxt;
                obs_row_d = obs_row_nxt;
                if (obs_last) state_d = S_UPDATE;
            end
`endif
            S_UPDATE: begin
                x_d = x_new;
                y_d = y_new;
                if (hit) begin
                    finish_d = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    state_d  = S_DRAW;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_INIT;
            x_q       <= 8'(X_START);
            y_q       <= 7'(Y_START);
            spr_k_q   <= '0;
            obs_col_q <= '0;
            obs_row_q <= '0;
            pend_q    <= 1'b0;
            finish_q  <= 1'b0;
            x_out_q   <= '0;
            y_out_q   <= '0;
            colour_q  <= '0;
            plot_q    <= 1'b0;
`ifdef OBSTACLE_BOUNCE_EN
            obs_y_q   <= 7'(OBS_Y);
            obs_dn_q  <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            spr_k_q   <= spr_k_d;
            obs_col_q <= obs_col_d;
            obs_row_q <= obs_row_d;
            pend_q    <= pend_d;
            finish_q  <= finish_d;
            x_out_q   <= x_out_d;
            y_out_q   <= y_out_d;
            colour_q  <= colour_d;
            plot_q    <= plot_d;
`ifdef OBSTACLE_BOUNCE_EN
            obs_y_q   <= obs_y_d;
            obs_dn_q  <= obs_dn_d;
`endif
        end
    end

    assign x_out      = x_out_q;
    assign y_out      = y_out_q;
    assign colour_out = colour_q;
    assign plot       = plot_q;
    assign finish     = finish_q;

endmodule

// File: tb/tb_object_datapath.sv
// Scoreboard bench for object_datapath (default build, TICKS_PER_STEP=4): expected pixels are
// queued as stimulus is applied and compared in order whenever the DUT strobes plot.
module tb_object_datapath;

    localparam logic [2:0] K_PLAYER = 3'b010;
    localparam logic [2:0] K_OBS    = 3'b100;
    localparam logic [2:0] K_BG     = 3'b000;

    logic       clock = 1'b0;
    logic       reset;
    logic       draw;
    logic       write_en;
    logic       move_up;
    logic       move_down;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] colour_out;
    logic       plot;
    logic       finish;

    int n_pass  = 0;
    int n_total = 0;
    int n_pix   = 0;

    logic [17:0] exp_q[$];
    int mx;
    int my;
    bit model_done;

    object_datapath #(.TICKS_PER_STEP(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .draw       (draw),
        .write_en   (write_en),
        .move_up    (move_up),
        .move_down  (move_down),
        .x_out      (x_out),
        .y_out      (y_out),
        .colour_out (colour_out),
        .plot       (plot),
        .finish     (finish)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [17:0] px(input int x, input int y, input logic [2:0] c);
        return {8'(x), 7'(y), c};
    endfunction

    task automatic push_sprite(input int x, input int y, input logic [2:0] c);
        for (int k = 0; k < 16; k++) exp_q.push_back(px(x + k % 4, y + k / 4, c));
    endtask

    task automatic push_obs();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 8; c++) exp_q.push_back(px(80 + c, 52 + r, K_OBS));
    endtask

    // Each plotted pixel must match the oldest expected one; a plot with nothing queued is an error.
    always @(negedge clock) begin
        if (plot === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_plot", 32'(plot), 32'd0);
            end else begin
                n_pix++;
                chk($sformatf("pixel%0d_xyc", n_pix), 32'({x_out, y_out, colour_out}),
                    32'(exp_q.pop_front()));
            end
        end
    end

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clock);
            #1;
            n++;
        end
        chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    // One movement step: erase old sprite, move, and either redraw or end the run.
    task automatic step(input logic up, input logic down, input string tag);
        move_up   = up;
        move_down = down;
        push_sprite(mx, my, K_BG);
        mx++;
        if (up && !down && my > 0) my--;
        else if (down && !up && my < 116) my++;
        model_done = ((mx <= 87) && (mx + 3 >= 80) && (my <= 67) && (my + 3 >= 52)) || (mx >= 152);
        if (!model_done) push_sprite(mx, my, K_PLAYER);
        drain(tag);
        chk({tag, "_finish_pre"}, 32'(finish), 32'd0);
        if (model_done) begin
            @(negedge clock);
            #1;
            chk({tag, "_finish_rise"}, 32'(finish), 32'd1);
        end
    endtask

    task automatic idle_watch(input int cycles, output int plots, output int fin_low);
        plots   = 0;
        fin_low = 0;
        repeat (cycles) begin
            @(negedge clock);
            #1;
            if (plot !== 1'b0) plots++;
            if (finish !== 1'b1) fin_low++;
        end
    endtask

    initial begin
        int plots;
        int fin_low;

        reset = 1'b1; draw = 1'b0; write_en = 1'b1; move_up = 1'b0; move_down = 1'b0;
        model_done = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_plot", 32'(plot), 32'd0);
        chk("rst_finish", 32'(finish), 32'd0);
        chk("rst_x", 32'(x_out), 32'd0);
        chk("rst_y", 32'(y_out), 32'd0);
        chk("rst_colour", 32'(colour_out), 32'd0);

        // Obstacle then sprite after reset.
        mx = 8; my = 56;
        push_obs();
        push_sprite(mx, my, K_PLAYER);
        reset = 1'b0; draw = 1'b1;
        drain("init");

        // draw=0 freezes motion.
        draw = 1'b0;
        plots = 0;
        repeat (20) begin
            @(negedge clock);
            #1;
            if (plot !== 1'b0) plots++;
        end
        chk("freeze_plots", 32'(plots), 32'd0);
        draw = 1'b1;

        step(1'b0, 1'b0, "step_nomove");
        step(1'b1, 1'b1, "step_both");

        // Sprite draw with write_en low: no plots, FSM still reaches S_WAIT.
        move_up = 1'b0; move_down = 1'b0;
        push_sprite(mx, my, K_BG);
        mx++;
        drain("we_erase");
        write_en = 1'b0;
        plots = 0;
        repeat (17) begin
            @(negedge clock);
            #1;
            if (plot !== 1'b0) plots++;
        end
        chk("we_off_plots", 32'(plots), 32'd0);
        write_en = 1'b1;

        step(1'b0, 1'b1, "step_down");
        step(1'b0, 1'b1, "step_down");
        for (int i = 0; i < 100 && my > 0; i++) step(1'b1, 1'b0, "step_up");
        repeat (3) step(1'b1, 1'b0, "step_up_clamp");
        for (int i = 0; i < 200 && !model_done; i++) step(1'b0, 1'b0, "step_goal");
        chk("goal_reached_x", 32'(mx), 32'd152);

        idle_watch(20, plots, fin_low);
        chk("done_plots", 32'(plots), 32'd0);
        chk("done_finish_held", 32'(fin_low), 32'd0);

        // Reset from S_DONE restores start position and clears finish.
        reset = 1'b1;
        @(negedge clock);
        #1;
        chk("rst2_finish", 32'(finish), 32'd0);
        chk("rst2_plot", 32'(plot), 32'd0);
        mx = 8; my = 56; model_done = 1'b0;
        push_obs();
        push_sprite(mx, my, K_PLAYER);
        reset = 1'b0;
        drain("reinit");
        step(1'b0, 1'b0, "pre_abort");
        step(1'b0, 1'b0, "pre_abort");

        // Abort in the middle of an erase.
        push_sprite(mx, my, K_BG);
        for (int n = 0; n < 500 && exp_q.size() > 11; n++) begin
            @(negedge clock);
            #1;
        end
        chk("abort_mid_erase", 32'(exp_q.size()), 32'd11);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clock);
        #1;
        chk("abort_plot", 32'(plot), 32'd0);
        chk("abort_finish", 32'(finish), 32'd0);
        mx = 8; my = 56; model_done = 1'b0;
        push_obs();
        push_sprite(mx, my, K_PLAYER);
        reset = 1'b0;
        drain("abort_reinit");

        // Straight run into the obstacle.
        for (int i = 0; i < 200 && !model_done; i++) step(1'b0, 1'b0, "step_collide");
        chk("collide_x", 32'(mx), 32'd77);
        idle_watch(20, plots, fin_low);
        chk("collide_plots", 32'(plots), 32'd0);
        chk("collide_finish_held", 32'(fin_low), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
